// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load-store unit:
//   - func3 access-size encodings (B, H, W, BU, HU)
//   - FSM state enum (IDLE, ACC0, ACC1, RESP)
//   - size-mask constants and the default memory-wait timeout
//   - helpers to classify a func3 value and derive its byte mask
// Optional feature macro used by the importing files: LSU_MISALIGN_SPLIT_EN
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access-size encodings on LSUfunc3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns for an access at offset 0
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Maximum cycles one memory access may wait for MEMready
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    function automatic logic func3_legal(input logic [2:0] f);
        case (f)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: func3_legal = 1'b1;
            default:                        func3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f);
        case (f)
            F3_B, F3_BU: size_mask = MASK_B;
            F3_H, F3_HU: size_mask = MASK_H;
            default:     size_mask = MASK_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane alignment shared by the store and load paths.
// Store side: shifts the write data and the size mask left by the byte offset
// into a 64-bit / 8-lane window; the low half feeds the first memory word,
// the high half the following word (only non-zero for word-crossing accesses).
// Load side: shifts the {high word, low word} pair right by the byte offset,
// truncates to the access size and sign- (B/H) or zero- (BU/HU/W) extends.
// The high-half outputs only matter when LSU_MISALIGN_SPLIT_EN is defined.
//
// Ports
//   i_func3     access size encoding
//   i_off       byte offset within the word (addr[1:0])
//   i_wdata     store data, right-justified
//   i_rword_lo  first (lower-address) read word
//   i_rword_hi  second (higher-address) read word
//   o_wdata_lo  lane-aligned store data for the first word
//   o_wdata_hi  lane-aligned store data for the following word
//   o_be_lo     byte enables for the first word
//   o_be_hi     byte enables for the following word
//   o_rdata     extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword_lo,
    input  logic [31:0] i_rword_hi,
    output logic [31:0] o_wdata_lo,
    output logic [31:0] o_wdata_hi,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_rdata
);

    logic [63:0] w_wdata_wide;
    logic [7:0]  w_be_wide;
    logic [31:0] w_rslice;

    assign w_wdata_wide = {32'd0, i_wdata} << {i_off, 3'b000};
    assign w_be_wide    = {4'd0, size_mask(i_func3)} << i_off;

    assign o_wdata_lo = w_wdata_wide[31:0];
    assign o_wdata_hi = w_wdata_wide[63:32];
    assign o_be_lo    = w_be_wide[3:0];
    assign o_be_hi    = w_be_wide[7:4];

    // Addressed byte lands in bits [7:0] after the right shift
    assign w_rslice = 32'({i_rword_hi, i_rword_lo} >> {i_off, 3'b000});

    always_comb begin
        case (i_func3)
            F3_B:    o_rdata = {{24{w_rslice[7]}}, w_rslice[7:0]};
            F3_H:    o_rdata = {{16{w_rslice[15]}}, w_rslice[15:0]};
            F3_BU:   o_rdata = {24'd0, w_rslice[7:0]};
            F3_HU:   o_rdata = {16'd0, w_rslice[15:0]};
            default: o_rdata = w_rslice;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu
// Load-store unit between the execute stage and a word-wide data memory.
// Accepts one request at a time from the core, sequences it as one (or, with
// LSU_MISALIGN_SPLIT_EN, two) word accesses over a req/ready handshake, and
// returns extended load data with a one-cycle LSUdone pulse. Illegal func3,
// unsupported misalignment and memory timeouts are reported on LSUerr.
//
// Optional feature: `define LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned accesses are supported; word-crossing ones are
//               split into ACC0 + ACC1
//   undefined - misaligned H/W accesses are rejected without a memory access
//
// Ports
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   LSUvalid       core request, held until LSUdone
//   LSUwe          1 = store, 0 = load
//   LSUfunc3       access size (B/H/W/BU/HU)
//   LSUaddr        byte address
//   LSUwdata       store data
//   LSUrdata       extended load data, held until the next load completes
//   LSUdone        one-cycle completion pulse
//   LSUerr         fault flag, qualified by LSUdone
//   LSUbusy        high while a request is in flight (through the done cycle)
//   MEMreq/MEMwe   memory request / write
//   MEMaddr        word address (bits [1:0] always 0)
//   MEMbe          byte enables
//   MEMwdata       lane-aligned write data
//   MEMrdata       read word, valid with MEMready
//   MEMready       access complete
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LSUvalid,
    input  logic        LSUwe,
    input  logic [2:0]  LSUfunc3,
    input  logic [31:0] LSUaddr,
    input  logic [31:0] LSUwdata,
    output logic [31:0] LSUrdata,
    output logic        LSUdone,
    output logic        LSUerr,
    output logic        LSUbusy,
    output logic        MEMreq,
    output logic        MEMwe,
    output logic [31:0] MEMaddr,
    output logic [3:0]  MEMbe,
    output logic [31:0] MEMwdata,
    input  logic [31:0] MEMrdata,
    input  logic        MEMready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // FSM state
    state_t r_state;
    state_t w_state_nxt;

    // Request captured at acceptance
    logic        r_we;
    logic [2:0]  r_func3;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    // Registered memory-side outputs and their next values
    logic        r_mem_req,   w_mem_req_nxt;
    logic        r_mem_we,    w_mem_we_nxt;
    logic [31:0] r_mem_addr,  w_mem_addr_nxt;
    logic [3:0]  r_mem_be,    w_mem_be_nxt;
    logic [31:0] r_mem_wdata, w_mem_wdata_nxt;

    // Per-access wait counter, fault flag and load result
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic [31:0]      r_rdata, w_rdata_nxt;

`ifdef LSU_MISALIGN_SPLIT_EN
    // First word of a split load, kept until ACC1 returns the second word
    logic [31:0] r_word0, w_word0_nxt;
`endif

    // Alignment inputs: live request while idle, captured request afterwards
    logic        w_idle;
    logic [2:0]  w_func3;
    logic [1:0]  w_off;
    logic [31:0] w_wdata;
    logic [31:0] w_rword_lo;
    logic [31:0] w_rword_hi;

    logic [31:0] w_wdata_lo, w_wdata_hi;
    logic [3:0]  w_be_lo, w_be_hi;
    logic [31:0] w_rdata_ext;

    logic w_reject;
    logic w_timeout;

    assign w_idle  = (r_state == S_IDLE);
    assign w_func3 = w_idle ? LSUfunc3      : r_func3;
    assign w_off   = w_idle ? LSUaddr[1:0]  : r_off;
    assign w_wdata = w_idle ? LSUwdata      : r_wdata;

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_rword_lo = (r_state == S_ACC1) ? r_word0 : MEMrdata;
    assign w_rword_hi = MEMrdata;
    assign w_reject   = !func3_legal(LSUfunc3);
`else
    logic w_misaligned;
    logic w_unused_hi;

    assign w_rword_lo   = MEMrdata;
    assign w_rword_hi   = '0;
    assign w_misaligned = (((LSUfunc3 == F3_H) || (LSUfunc3 == F3_HU)) && LSUaddr[0]) ||
                          ((LSUfunc3 == F3_W) && (LSUaddr[1:0] != 2'b00));
    assign w_reject     = !func3_legal(LSUfunc3) || w_misaligned;
    // Second-word lanes are never needed when accesses cannot cross a word
    assign w_unused_hi  = ^{w_be_hi, w_wdata_hi};
`endif

    // Reaching the last allowed wait cycle without MEMready aborts the access
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    lsu_align u_align (
        .i_func3    (w_func3),
        .i_off      (w_off),
        .i_wdata    (w_wdata),
        .i_rword_lo (w_rword_lo),
        .i_rword_hi (w_rword_hi),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_be_lo    (w_be_lo),
        .o_be_hi    (w_be_hi),
        .o_rdata    (w_rdata_ext)
    );

    // Next-state and next-output logic
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_rdata_nxt     = r_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        w_word0_nxt     = r_word0;
`endif

        case (r_state)
            S_IDLE: begin
                if (LSUvalid) begin
                    if (w_reject) begin
                        w_state_nxt = S_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = S_ACC0;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = LSUwe;
                        w_mem_addr_nxt  = {LSUaddr[31:2], 2'b00};
                        w_mem_be_nxt    = w_be_lo;
                        w_mem_wdata_nxt = w_wdata_lo;
                        w_cnt_nxt       = '0;
                        w_err_nxt       = 1'b0;
                    end
                end
            end

`ifdef LSU_MISALIGN_SPLIT_EN
            S_ACC0, S_ACC1: begin
`else
            S_ACC0: begin
`endif
                if (MEMready) begin
                    w_state_nxt   = S_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    if (!r_we) begin
                        w_rdata_nxt = w_rdata_ext;
                    end
`ifdef LSU_MISALIGN_SPLIT_EN
                    // Word-crossing access: keep MEMreq high and move straight
                    // on to the next word, holding the first read word aside.
                    if ((r_state == S_ACC0) && (w_be_hi != 4'b0000)) begin
                        w_state_nxt     = S_ACC1;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_addr_nxt  = r_mem_addr + 32'd4;
                        w_mem_be_nxt    = w_be_hi;
                        w_mem_wdata_nxt = w_wdata_hi;
                        w_word0_nxt     = MEMrdata;
                        w_rdata_nxt     = r_rdata;
                    end
`endif
                end else if (w_timeout) begin
                    w_state_nxt   = S_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            // No acceptance here: a request still held high from the one just
            // completed must not be taken a second time.
            S_RESP:  w_state_nxt = S_IDLE;

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
        end
    end

    // Datapath and memory-interface registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we        <= 1'b0;
            r_func3     <= '0;
            r_off       <= '0;
            r_wdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_word0     <= '0;
`endif
        end else begin
            if (w_idle && LSUvalid) begin
                r_we    <= LSUwe;
                r_func3 <= LSUfunc3;
                r_off   <= LSUaddr[1:0];
                r_wdata <= LSUwdata;
            end
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_word0     <= w_word0_nxt;
`endif
        end
    end

    assign LSUrdata = r_rdata;
    assign LSUdone  = (r_state == S_RESP);
    assign LSUerr   = LSUdone && r_err;
    assign LSUbusy  = !w_idle;
    assign MEMreq   = r_mem_req;
    assign MEMwe    = r_mem_we;
    assign MEMaddr  = r_mem_addr;
    assign MEMbe    = r_mem_be;
    assign MEMwdata = r_mem_wdata;

endmodule

// File: doc/lsu.md
# lsu

Load-store unit between the execute stage (ALU address, register-file rs2) and the data memory. It sequences byte, halfword and word loads/stores over a word-wide memory bus with a req/ready handshake, stalling the core through `LSUbusy`. It returns sign- or zero-extended load data to the writeback mux and flags illegal, misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, 16: maximum cycles one memory access may wait for `MEMready` before abort.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `LSUvalid`  in  1  core request; held high until `LSUdone`.
- `LSUwe`  in  1  1 = store (S-type), 0 = load.
- `LSUfunc3`  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; other values are illegal.
- `LSUaddr`  in  32  byte address from the ALU.
- `LSUwdata`  in  32  store data (rs2).
- `LSUrdata`  out  32  extended load data; registered and held until the next load completes.
- `LSUdone`  out  1  one-cycle completion pulse.
- `LSUerr`  out  1  fault, valid only with `LSUdone`.
- `LSUbusy`  out  1  high from acceptance through the `LSUdone` cycle.
- `MEMreq`  out  1  memory request.
- `MEMwe`  out  1  memory write.
- `MEMaddr`  out  32  word address; bits [1:0] are always 00.
- `MEMbe`  out  4  byte enables.
- `MEMwdata`  out  32  lane-aligned write data.
- `MEMrdata`  in  32  read word; valid in the `MEMready` cycle.
- `MEMready`  in  1  access complete.

## Operation
- FSM states and transitions:
  - IDLE → ACC0 on `LSUvalid`.
  - IDLE → RESP (error, no memory access) if `LSUvalid` arrives with an illegal `func3` or an unsupported misalignment.
  - ACC0 → ACC1 when ACC0 completes and the access is split.
  - ACC0 or ACC1 → RESP on completion or timeout.
  - RESP → IDLE unconditionally.
- Capture on acceptance, in IDLE: `we`, `func3`, `addr` and `wdata` are registered. Later input changes are ignored, and the operation completes even if `LSUvalid` drops.
- Lane mapping:
  - `off` = `addr[1:0]`; size mask `m` = 0001, 0011 or 1111.
  - 64-bit data = `wdata << 8*off`; 8-bit mask = `m << off`.
  - ACC0 uses the low 32 data bits and low 4 mask bits at `addr & ~3`.
  - ACC1 uses the high halves at `(addr & ~3) + 4`. The address wraps modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
- Load data: the words are concatenated as `{ACC1 word, ACC0 word}`, shifted right by `8*off`, truncated to the access size, then sign-extended (B/H) or zero-extended (BU/HU/W).
- Alignment: H is aligned when `off[0]`=0; W is aligned when `off`=0.
- Memory handshake:
  - `MEMreq`, `MEMaddr`, `MEMbe`, `MEMwdata` and `MEMwe` are registered and held stable until a rising edge samples `MEMready`=1.
  - `MEMreq` drops after that edge unless the next access follows directly.
  - ACC1 asserts `MEMreq` in the cycle immediately after ACC0 completes.
- Timeout: a per-access counter increments each cycle that `MEMreq`=1 and `MEMready`=0. When it reaches `TIMEOUT`, `MEMreq` drops, the FSM goes to RESP with `LSUerr`=1, and `LSUrdata` is unchanged.
- Stores never modify `LSUrdata`.
- Reset values:
  - All outputs are 0.
  - State is IDLE and the counter is 0.
  - A reset mid-access drops `MEMreq` immediately (asynchronously), and the access is discarded.

## Timing
- Normal access, `MEMready` high immediately:
  - `LSUvalid` is sampled at edge 0.
  - `MEMreq` is high in cycle 1.
  - `LSUdone` is high in cycle 2.
- Each wait cycle adds 1; a split access adds 1 plus ACC1's wait cycles.
- Error without memory access: `LSUdone`/`LSUerr` are high in cycle 1.
- `LSUvalid` is never accepted in RESP; the next request is accepted no earlier than the first cycle back in IDLE. This prevents re-accepting the same held request.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - A misaligned access within one word (`off + size` ≤ 4) uses one access.
  - A word-crossing access is split into ACC0 + ACC1.
  - `LSUerr` is set only for an illegal `func3` or a timeout.
- Undefined:
  - Any misaligned H/W access takes the IDLE → RESP path with `LSUerr`=1.
  - The ACC1 state and the split logic are not compiled.

## Structure
- `lsu_pkg`:
  - `func3` encodings and the FSM state enum (IDLE, ACC0, ACC1, RESP).
  - Size-mask constants and the default `TIMEOUT`.
- Sub-module `lsu_align`: combinational lane shift for store data/mask and load extraction/extension, shared by both paths.

## Test plan
- LW at 0x100, memory word 0xDEADBEEF, `MEMready` immediate:
  - `MEMreq` in cycle 1, `MEMaddr`=0x100, `MEMbe`=1111.
  - `LSUdone` in cycle 2 with `LSUrdata`=0xDEADBEEF.
- LB/LBU at 0x103 with word 0x80000000 → `MEMbe`=1000; `LSUrdata`=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH at 0x102, wdata 0x1234ABCD → `MEMbe`=1100, `MEMwdata`=0xABCDxxxx, `MEMwe`=1.
- LW at 0xFFFFFFFE:
  - Without the macro: `LSUerr` in cycle 1, `MEMreq` never asserted.
  - With the macro: accesses to 0xFFFFFFFC then 0x00000000, and `LSUrdata` = {low 2 bytes of word 0x00000000 as bits [31:16], high 2 bytes of word 0xFFFFFFFC as bits [15:0]}.
- `MEMready` held low → `MEMreq` drops after 16 wait cycles, `LSUdone`+`LSUerr` pulse, `LSUrdata` unchanged.
- `reset` asserted while `MEMreq`=1 → all outputs 0 immediately; the next request after reset release completes normally.
